// File: rtl/s1488_bist_driver.sv
// BIST driver for the s1488 controller: flushes its state with zero inputs, then applies
// LFSR vectors and compacts each response into a MISR, reporting signature and pass/fail.
module s1488_bist_driver #(
   parameter int unsigned N_PATTERNS   = 127,
   parameter int unsigned FLUSH_CYCLES = 8,
   parameter logic [6:0]  LFSR_SEED    = 7'h01,
   parameter logic [18:0] GOLDEN_SIG   = 19'h00000
) (
   input  logic        CK,
   input  logic        CLR,
   input  logic        start,
   output logic [6:0]  cut_v,
   input  logic [18:0] cut_resp,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [18:0] signature
);

   localparam logic [15:0] LP_LAST_PAT   = 16'(N_PATTERNS - 1);
   localparam logic [7:0]  LP_LAST_FLUSH = 8'(FLUSH_CYCLES - 1);
   localparam logic [18:0] LP_MISR_POLY  = 19'h00027;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FLUSH = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   logic [7:0]  r_flush_cnt;
   logic [15:0] r_pat_cnt;
   logic [6:0]  r_lfsr;
   logic [18:0] r_misr;
   logic [6:0]  r_cut_v;
   logic        r_busy;
   logic        r_done;
   logic        r_pass;

   logic [18:0] w_misr_next;
   logic [6:0]  w_lfsr_next;

   // x^19+x^5+x^2+x+1, response folded in on the same shift
   function automatic logic [18:0] misr_step(input logic [18:0] m, input logic [18:0] d);
      return {m[17:0], 1'b0} ^ (m[18] ? LP_MISR_POLY : 19'h00000) ^ d;
   endfunction

   function automatic logic [6:0] lfsr_step(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction

   assign w_misr_next = misr_step(r_misr, cut_resp);
   assign w_lfsr_next = lfsr_step(r_lfsr);

   always_ff @(posedge CK or negedge CLR) begin
      if (!CLR) begin
         r_state     <= S_IDLE;
         r_flush_cnt <= 8'd0;
         r_pat_cnt   <= 16'd0;
         r_lfsr      <= 7'h00;
         r_misr      <= 19'h00000;
         r_cut_v     <= 7'h00;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state     <= S_FLUSH;
                  r_flush_cnt <= 8'd0;
                  r_pat_cnt   <= 16'd0;
                  r_lfsr      <= LFSR_SEED;
                  r_misr      <= 19'h00000;
                  r_cut_v     <= 7'h00;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
               end
            end
            S_FLUSH: begin
               if (r_flush_cnt == LP_LAST_FLUSH) begin
                  r_state <= S_RUN;
                  r_cut_v <= LFSR_SEED;
               end else begin
                  r_flush_cnt <= r_flush_cnt + 8'd1;
               end
            end
            S_RUN: begin
               r_misr    <= w_misr_next;
               r_lfsr    <= w_lfsr_next;
               r_pat_cnt <= r_pat_cnt + 16'd1;
               // the edge absorbing the final response also grades it
               if (r_pat_cnt == LP_LAST_PAT) begin
                  r_state <= S_DONE;
                  r_cut_v <= 7'h00;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_misr_next == GOLDEN_SIG);
               end else begin
                  r_cut_v <= w_lfsr_next;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cut_v     = r_cut_v;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign signature = r_misr;

endmodule

// File: tb/tb_s1488_bist_driver.sv
// Directed bench for s1488_bist_driver: several parameterisations run side by side
// on one clock, each with its own start and response inputs.
module tb_s1488_bist_driver;

   logic CK;
   logic CLR;

   logic st_a, st_b, st_b2, st_c, st_d;
   logic [18:0] rsp_a, rsp_b, rsp_b2, rsp_c, rsp_d;
   logic [6:0]  v_a, v_b, v_b2, v_c, v_d;
   logic busy_a, busy_b, busy_b2, busy_c, busy_d;
   logic done_a, done_b, done_b2, done_c, done_d;
   logic pass_a, pass_b, pass_b2, pass_c, pass_d;
   logic [18:0] sig_a, sig_b, sig_b2, sig_c, sig_d;

   int n_chk;
   int n_fail;
   logic [6:0] seq [8];

   s1488_bist_driver #(.N_PATTERNS(10), .FLUSH_CYCLES(8), .LFSR_SEED(7'h01), .GOLDEN_SIG(19'h003FF)) u_a (
      .CK(CK), .CLR(CLR), .start(st_a), .cut_v(v_a), .cut_resp(rsp_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));
   s1488_bist_driver #(.N_PATTERNS(2), .FLUSH_CYCLES(3), .LFSR_SEED(7'h01), .GOLDEN_SIG(19'h00003)) u_b (
      .CK(CK), .CLR(CLR), .start(st_b), .cut_v(v_b), .cut_resp(rsp_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));
   s1488_bist_driver #(.N_PATTERNS(2), .FLUSH_CYCLES(3), .LFSR_SEED(7'h01), .GOLDEN_SIG(19'h40027)) u_b2 (
      .CK(CK), .CLR(CLR), .start(st_b2), .cut_v(v_b2), .cut_resp(rsp_b2),
      .busy(busy_b2), .done(done_b2), .pass(pass_b2), .signature(sig_b2));
   s1488_bist_driver #(.N_PATTERNS(4), .FLUSH_CYCLES(2), .LFSR_SEED(7'h01), .GOLDEN_SIG(19'h00001)) u_c (
      .CK(CK), .CLR(CLR), .start(st_c), .cut_v(v_c), .cut_resp(rsp_c),
      .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c));
   s1488_bist_driver #(.N_PATTERNS(130), .FLUSH_CYCLES(1), .LFSR_SEED(7'h01), .GOLDEN_SIG(19'h00000)) u_d (
      .CK(CK), .CLR(CLR), .start(st_d), .cut_v(v_d), .cut_resp(rsp_d),
      .busy(busy_d), .done(done_d), .pass(pass_d), .signature(sig_d));

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      seq[0] = 7'h01; seq[1] = 7'h02; seq[2] = 7'h04; seq[3] = 7'h08;
      seq[4] = 7'h10; seq[5] = 7'h20; seq[6] = 7'h41; seq[7] = 7'h03;
      st_a = 0; st_b = 0; st_b2 = 0; st_c = 0; st_d = 0;
      rsp_a = 19'h00001; rsp_b = 19'h00001; rsp_b2 = 19'h40000;
      rsp_c = 19'h00000; rsp_d = 19'h00000;

      // asynchronous reset before any clock edge
      CLR = 1'b1;
      #2 CLR = 1'b0;
      #1;
      chk("rst cut_v", 32'(v_a), 32'h0);
      chk("rst busy", 32'(busy_a), 32'h0);
      chk("rst done", 32'(done_a), 32'h0);
      chk("rst pass", 32'(pass_a), 32'h0);
      chk("rst sig", 32'(sig_a), 32'h0);
      #1 CLR = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("idle busy", 32'(busy_a), 32'h0);
      chk("idle sig", 32'(sig_a), 32'h0);
      chk("idle done", 32'(done_d), 32'h0);

      // run 1: all instances start together
      st_a = 1; st_b = 1; st_b2 = 1; st_c = 1; st_d = 1;
      step();
      st_a = 0; st_b = 0; st_b2 = 0; st_c = 0; st_d = 0;
      chk("A busy at start", 32'(busy_a), 32'h1);
      chk("A cut_v at start", 32'(v_a), 32'h0);
      for (int c = 1; c <= 131; c++) begin
         step();
         if (c <= 7) chk("A flush cut_v", 32'(v_a), 32'h0);
         if (c >= 8 && c <= 15) chk("A lfsr cut_v", 32'(v_a), 32'(seq[c-8]));
         if (c == 12) st_a = 1;
         if (c == 13) st_a = 0;
         if (c == 17) begin
            chk("A done early", 32'(done_a), 32'h0);
            chk("A busy late", 32'(busy_a), 32'h1);
         end
         if (c == 18) begin
            chk("A done", 32'(done_a), 32'h1);
            chk("A busy end", 32'(busy_a), 32'h0);
            chk("A cut_v end", 32'(v_a), 32'h0);
            chk("A sig", 32'(sig_a), 32'h3FF);
            chk("A pass", 32'(pass_a), 32'h1);
         end
         if (c == 25) begin
            chk("A done hold", 32'(done_a), 32'h1);
            chk("A sig hold", 32'(sig_a), 32'h3FF);
         end
         if (c == 4) chk("B done early", 32'(done_b), 32'h0);
         if (c == 5) begin
            chk("B done", 32'(done_b), 32'h1);
            chk("B sig", 32'(sig_b), 32'h00003);
            chk("B pass", 32'(pass_b), 32'h1);
            chk("B2 sig", 32'(sig_b2), 32'h40027);
            chk("B2 pass", 32'(pass_b2), 32'h1);
         end
         if (c == 6) begin
            chk("C done", 32'(done_c), 32'h1);
            chk("C sig", 32'(sig_c), 32'h0);
            chk("C pass", 32'(pass_c), 32'h0);
         end
         if (c == 1) chk("D cut_v p1", 32'(v_d), 32'h01);
         if (c == 2) chk("D cut_v p2", 32'(v_d), 32'h02);
         if (c == 128) chk("D cut_v wrap", 32'(v_d), 32'h01);
         if (c == 130) chk("D done early", 32'(done_d), 32'h0);
         if (c == 131) begin
            chk("D done", 32'(done_d), 32'h1);
            chk("D pass", 32'(pass_d), 32'h1);
            chk("D sig", 32'(sig_d), 32'h0);
         end
      end

      // run 2: start held high through DONE on A
      st_a = 1;
      step();
      chk("A2 busy", 32'(busy_a), 32'h1);
      chk("A2 done drop", 32'(done_a), 32'h0);
      for (int d = 1; d <= 37; d++) begin
         step();
         if (d == 18) begin
            chk("A2 first done", 32'(done_a), 32'h1);
            chk("A2 first sig", 32'(sig_a), 32'h3FF);
         end
         if (d == 19) begin
            chk("A2 restart done", 32'(done_a), 32'h0);
            chk("A2 restart busy", 32'(busy_a), 32'h1);
         end
         if (d == 37) begin
            chk("A2 second done", 32'(done_a), 32'h1);
            chk("A2 second sig", 32'(sig_a), 32'h3FF);
            chk("A2 second pass", 32'(pass_a), 32'h1);
         end
      end
      st_a = 0;

      // run 3: abort D mid-RUN with CLR
      rsp_d = 19'h00001;
      st_d = 1;
      step();
      st_d = 0;
      for (int c = 1; c <= 51; c++) step();
      chk("D busy mid", 32'(busy_d), 32'h1);
      #2 CLR = 1'b0;
      #1;
      chk("abort D sig", 32'(sig_d), 32'h0);
      chk("abort D busy", 32'(busy_d), 32'h0);
      chk("abort D cut_v", 32'(v_d), 32'h0);
      chk("abort A done", 32'(done_a), 32'h0);
      chk("abort A sig", 32'(sig_a), 32'h0);
      chk("abort A pass", 32'(pass_a), 32'h0);
      #1 CLR = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("post D sig", 32'(sig_d), 32'h0);
      chk("post D busy", 32'(busy_d), 32'h0);
      chk("post D done", 32'(done_d), 32'h0);
      chk("post A done", 32'(done_a), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
